div_8by4_seq: RTL
=================

# div_8by4_seq

Sequential shift/subtract (restoring) unsigned divider; the inverse companion of the team's 4-bit shift/add multiplier. It takes a 2·BITS-bit dividend, such as a multiplier product, and a BITS-bit divisor. It produces a 2·BITS-bit quotient and a BITS-bit remainder, computing one quotient bit per enabled clock. A start/busy/done handshake lets the top-level wrapper launch an operation and collect the result.

## Interface
- BITS, 4, divisor/remainder width; dividend and quotient are 2·BITS wide.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state while low.
- ena  input  1  clock enable; when low, all state is frozen.
- start  input  1  request; sampled on the rising edge with ena=1.
- io_Dividend  input  2·BITS  dividend, captured when start is accepted.
- io_Divisor  input  BITS  divisor, captured when start is accepted.
- io_Quotient  output  2·BITS  quotient; valid while done=1.
- io_Remainder  output  BITS  remainder; valid while done=1.
- busy  output  1  high while iterating.
- done  output  1  high when the result is valid; held until the next accepted start.
- div_by_zero  output  1  high with done when the captured divisor was 0.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Reset (rst=0):
  - state=IDLE, step counter=0.
  - Quotient, remainder and dividend shift registers = 0.
  - busy=0, done=0, div_by_zero=0.
- start is accepted in IDLE or DONE when start=1 and ena=1.
  - Operands are captured into internal registers.
  - done and div_by_zero are cleared.
  - If the divisor is nonzero: go to RUN, counter=0, partial remainder R (BITS+1 bits)=0.
  - If the divisor is 0: go directly to DONE with quotient = all ones (2^(2·BITS)−1), remainder=0, div_by_zero=1.
- start while in RUN is ignored. Operands must be stable only at the accept edge.
- Each enabled RUN edge performs one iteration:
  - R ← {R[BITS−1:0], dividend MSB}; the dividend register shifts left by 1.
  - If R ≥ divisor: R ← R − divisor and the new quotient LSB = 1. Otherwise the quotient LSB = 0.
  - The quotient register shifts left, inserting that bit.
  - The counter increments.
- After iteration 2·BITS (counter wraps from 2·BITS−1): go to DONE, done=1, busy=0.
- Width rule: R never exceeds 2·divisor−1 before the compare, so BITS+1 bits suffice. The final R fits in BITS bits.
- Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor.
- DONE holds outputs indefinitely. The next accepted start leaves DONE on that edge.
- ena=0 freezes state, counter and datapath. start is not sampled while ena=0. Outputs hold their values.
- rst falling mid-operation aborts immediately and returns to reset values. No partial result is retained.

## Timing
- Accept edge E0 takes the FSM to RUN; busy=1 after E0.
- Iterations occur on the next 2·BITS enabled edges.
- done=1 and valid results appear after enabled edge 2·BITS following E0 (8 enabled cycles for BITS=4).
- Each ena=0 cycle during RUN extends latency by exactly one cycle.
- Divide-by-zero latency: done=1 after E0 itself (1 cycle).
- busy and done are never high together. busy falls and done rises on the same edge.
- Back-to-back operations: start held high in DONE relaunches on the first enabled edge. Throughput is one result per 2·BITS+1 enabled cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Dividend 200, divisor 7, start 1 cycle -> busy for 8 cycles, then done=1, quotient=28, remainder=4, div_by_zero=0.
- Edge values, run one after another:
  - 255/1 -> q=255, r=0.
  - 225/15 -> q=15, r=0.
  - 5/9 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
- Dividend 13, divisor 0 -> done=1 one edge after accept, quotient=255, remainder=0, div_by_zero=1, busy never high.
- 200/7 with ena low for 3 cycles mid-RUN -> done arrives after 11 cycles. Results are unchanged (28 r4) and the state is frozen during each gap.
- start pulsed again during RUN with 99/5 -> ignored; result is still 28 r4. A subsequent start from DONE yields q=19, r=4.
- rst driven low at iteration 4, asynchronously between edges -> busy/done/quotient clear immediately. After release, the FSM is in IDLE and a new 100/10 gives 10 r0.

Source files
------------

// File: rtl/div_8by4_seq_if.sv
// ============================================================================
// Module      : div_8by4_seq_if
// Description : Handshake and operand/result bundle for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_8by4_seq_if #(
    parameter int BITS = 4
);
    logic                  ena;
    logic                  start;
    logic [2*BITS-1:0]     io_Dividend;
    logic [BITS-1:0]       io_Divisor;
    logic [2*BITS-1:0]     io_Quotient;
    logic [BITS-1:0]       io_Remainder;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;

    modport master (
        output ena, start, io_Dividend, io_Divisor,
        input  io_Quotient, io_Remainder, busy, done, div_by_zero
    );

    modport slave (
        input  ena, start, io_Dividend, io_Divisor,
        output io_Quotient, io_Remainder, busy, done, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/div_8by4_seq.sv
// ============================================================================
// Module      : div_8by4_seq
// Description : Restoring shift/subtract divider, 2*BITS / BITS, one bit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_8by4_seq #(
    parameter int BITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    div_8by4_seq_if.slave      bus
);
    localparam int CW = $clog2(2*BITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] c_last = CW'(2*BITS-1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2*BITS-1:0]   r_dvd;
    logic [BITS-1:0]     r_dvs;
    logic [BITS-1:0]     r_rem;
    logic [2*BITS-1:0]   r_quo;
    logic                r_busy;
    logic                r_done;
    logic                r_dbz;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_accept;
    logic                w_dvs_zero;
    logic [BITS:0]       w_shift;
    logic [BITS:0]       w_sub;
    logic                w_ge;

    assign w_dvs_zero = (bus.io_Divisor == '0);
    assign w_accept   = bus.ena && bus.start && (r_state != S_RUN);

    // Partial remainder needs one extra bit only between shift and compare.
    assign w_shift = {r_rem, r_dvd[2*BITS-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift - {1'b0, r_dvs};

    // State register and registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.ena) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state keeps busy/done registered
    always_comb begin
        w_busy_nxt = (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_dbz <= 1'b0;
        end else if (bus.ena) begin
            if (w_accept) begin
                r_dvd <= bus.io_Dividend;
                r_dvs <= bus.io_Divisor;
                r_cnt <= '0;
                r_rem <= '0;
                r_quo <= w_dvs_zero ? '1 : '0;
                r_dbz <= w_dvs_zero;
            end else if (r_state == S_RUN) begin
                r_dvd <= {r_dvd[2*BITS-2:0], 1'b0};
                r_rem <= BITS'(w_ge ? w_sub : w_shift);
                r_quo <= {r_quo[2*BITS-2:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.io_Quotient  = r_quo;
    assign bus.io_Remainder = r_rem;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.div_by_zero  = r_dbz;

endmodule

`default_nettype wire
